// File: rtl/retire_commit_unit.sv
// Retire/commit stage: writes the 2-wide retire stream into the ARF and the
// committed arch-to-tag map, and recycles superseded tags through a free-tag FIFO.
module retire_commit_unit #(
   parameter int NUM_REG       = 32,
   parameter int NUM_REG_LOG2  = $clog2(NUM_REG),
   parameter int NUM_TAGS      = 64,
   parameter int NUM_TAGS_LOG2 = $clog2(NUM_TAGS),
   parameter int REG_SIZE      = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REG_LOG2-1:0]    i_retire_reg      [2],
   input  logic [NUM_TAGS_LOG2-1:0]   i_retire_tag      [2],
   input  logic [REG_SIZE-1:0]        i_retire_reg_data [2],
   input  logic [1:0]                 i_retire_valid,
   input  logic                       i_alloc_req,
   output logic [NUM_TAGS_LOG2-1:0]   o_alloc_tag,
   output logic                       o_alloc_valid,
   input  logic [NUM_REG_LOG2-1:0]    i_rs_addr         [2],
   output logic [REG_SIZE-1:0]        o_rs_data         [2],
   output logic [NUM_TAGS_LOG2:0]     o_free_count,
   output logic                       o_fl_overflow
);

   localparam int CW = NUM_TAGS_LOG2 + 2;

   typedef logic [NUM_TAGS_LOG2-1:0] tag_t;

   logic [REG_SIZE-1:0]   r_arf [NUM_REG];
   tag_t                  r_map [NUM_REG];
   tag_t                  r_fl  [NUM_TAGS];
   tag_t                  r_head;
   tag_t                  r_tail;
   logic [NUM_TAGS_LOG2:0] r_count;
   logic                  r_overflow;

   logic                  w_live0;
   logic                  w_live1;
   logic                  w_commit0;
   logic                  w_commit1;
   logic                  w_sameReg;
   tag_t                  w_oldTag0;
   tag_t                  w_oldTag1;
   tag_t                  w_push0;
   tag_t                  w_push1;
   logic [1:0]            w_pushReq;
   logic [1:0]            w_pushAcc;
   logic                  w_pop;
   logic [CW-1:0]         w_room;
   logic                  w_dropped;

   // Slot qualification and freed-tag selection. When both slots hit the same
   // arch reg, slot 1 supersedes slot 0's tag, so slot 0's tag is what it frees.
   always_comb begin
      w_live0   = i_retire_valid[0] && (i_retire_tag[0] != '0);
      w_live1   = i_retire_valid[0] && i_retire_valid[1] && (i_retire_tag[1] != '0);
      w_commit0 = w_live0 && (i_retire_reg[0] != '0);
      w_commit1 = w_live1 && (i_retire_reg[1] != '0);
      w_sameReg = w_commit0 && w_commit1 && (i_retire_reg[0] == i_retire_reg[1]);
      w_oldTag0 = r_map[i_retire_reg[0]];
      w_oldTag1 = w_sameReg ? i_retire_tag[0] : r_map[i_retire_reg[1]];
      w_pushReq = {1'b0, w_commit0} + {1'b0, w_commit1};
      w_push0   = w_commit0 ? w_oldTag0 : w_oldTag1;
      w_push1   = w_oldTag1;
   end

   // A same-cycle pop frees one slot, so it counts toward room for the pushes.
   always_comb begin
      w_pop     = i_alloc_req && (r_count != '0);
      w_room    = CW'(NUM_TAGS) - CW'(r_count) + CW'(w_pop);
      w_pushAcc = w_pushReq;
      w_dropped = 1'b0;
      if (CW'(w_pushReq) > w_room) begin
         w_pushAcc = w_room[1:0];
         w_dropped = 1'b1;
      end
   end

   assign o_alloc_tag   = r_fl[r_head];
   assign o_alloc_valid = (r_count != '0);
   assign o_free_count  = r_count;
   assign o_fl_overflow = r_overflow;

   // Read ports see this cycle's commits; slot 1 is younger so it takes priority.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         o_rs_data[i] = r_arf[i_rs_addr[i]];
         if (i_rs_addr[i] == '0) begin
            o_rs_data[i] = '0;
         end else if (w_commit1 && (i_retire_reg[1] == i_rs_addr[i])) begin
            o_rs_data[i] = i_retire_reg_data[1];
         end else if (w_commit0 && (i_retire_reg[0] == i_rs_addr[i])) begin
            o_rs_data[i] = i_retire_reg_data[0];
         end
      end
   end

   // Pointer wrap relies on NUM_TAGS being a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REG; i++) begin
            r_arf[i] <= '0;
            r_map[i] <= tag_t'(i);
         end
         for (int i = 0; i < NUM_TAGS; i++) begin
            r_fl[i] <= (i < NUM_TAGS - NUM_REG) ? tag_t'(NUM_REG + i) : '0;
         end
         r_head     <= '0;
         r_tail     <= tag_t'(NUM_TAGS - NUM_REG);
         r_count    <= (NUM_TAGS_LOG2+1)'(NUM_TAGS - NUM_REG);
         r_overflow <= 1'b0;
      end else begin
         if (w_commit0) begin
            r_arf[i_retire_reg[0]] <= i_retire_reg_data[0];
            r_map[i_retire_reg[0]] <= i_retire_tag[0];
         end
         if (w_commit1) begin
            r_arf[i_retire_reg[1]] <= i_retire_reg_data[1];
            r_map[i_retire_reg[1]] <= i_retire_tag[1];
         end
         if (w_pushAcc != 2'd0) begin
            r_fl[r_tail] <= w_push0;
         end
         if (w_pushAcc == 2'd2) begin
            r_fl[r_tail + tag_t'(1)] <= w_push1;
         end
         r_tail <= r_tail + tag_t'(w_pushAcc);
         if (w_pop) begin
            r_head <= r_head + tag_t'(1);
         end
         r_count <= r_count + (NUM_TAGS_LOG2+1)'(w_pushAcc) - (NUM_TAGS_LOG2+1)'(w_pop);
         if (w_dropped) begin
            r_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: doc/retire_commit_unit.md
Name: retire_commit_unit

Overview:
- Consumer end of the reorder buffer's 2-wide retire interface.
- Commits retired results into the architectural register file (ARF) and keeps the committed arch-to-tag map.
- Returns each superseded physical tag to a free-tag FIFO, which the rename stage pops one tag per cycle.
- Provides 2 ARF read ports for dispatch, with same-cycle retire bypass.

Parameters:
NUM_REG, 32, architectural registers
NUM_REG_LOG2, $clog2(NUM_REG), arch index width
NUM_TAGS, 64, physical tags; also free-list depth
NUM_TAGS_LOG2, $clog2(NUM_TAGS), tag width
REG_SIZE, 32, data width

Ports:
clk  input  1  clock
rst  input  1  reset
retire_reg[0:1]  input  NUM_REG_LOG2 each  retiring arch rd
retire_tag[0:1]  input  NUM_TAGS_LOG2 each  retiring tag
retire_reg_data[0:1]  input  REG_SIZE each  retiring value
retire_valid  input  2  per-slot valid; slot 0 is older
alloc_req  input  1  rename requests one tag
alloc_tag  output  NUM_TAGS_LOG2  tag at free-list head
alloc_valid  output  1  free list non-empty
rs_addr[0:1]  input  NUM_REG_LOG2 each  ARF read address
rs_data[0:1]  output  REG_SIZE each  ARF read data
free_count  output  NUM_TAGS_LOG2+1  tags in free list
fl_overflow  output  1  sticky error flag

Behaviour:
- Reset: rst is synchronous, active-high, on clk. On reset:
  - ARF is all zero.
  - commit_map[i] = i for i in 0..NUM_REG-1.
  - Free list holds tags NUM_REG..NUM_TAGS-1 in ascending order, with head at tag 32.
  - free_count = 32; alloc_valid = 1; alloc_tag = 32; fl_overflow = 0.
- Reset has priority over all other activity. Pushes, pops and writes in the reset cycle are discarded.
- Slot validity: a slot is "live" when its retire_valid bit is set and retire_tag != 0. Tag 0 means the instruction has no destination.
  - Slot 1 is considered only if retire_valid[0] = 1. The pattern 2'b10 is ignored entirely.
- A live slot whose retire_reg is 0 is dropped: no ARF write, no map update, no push.
- Commit of a live slot k: ARF[retire_reg[k]] <= retire_reg_data[k], commit_map[retire_reg[k]] <= retire_tag[k], and the previous mapping is pushed to the free list.
- Both slots live with the same arch reg:
  - Slot 1 wins the ARF and commit_map.
  - Pushes, in order: old commit_map value, then retire_tag[0].
  - commit_map ends holding retire_tag[1].
- Push order across slots is slot 0's freed tag, then slot 1's. All updates are registered and visible the following cycle.
- Free list is a circular FIFO of depth NUM_TAGS, with head/tail pointers wrapping mod NUM_TAGS.
  - Up to 2 pushes per cycle at the tail (tail advances by 0, 1 or 2).
  - At most 1 pop per cycle at the head.
- Pop:
  - alloc_tag is combinational from fl[head].
  - alloc_valid = (free_count != 0).
  - A pop occurs when alloc_req & alloc_valid; head then advances by 1 at the clock edge.
  - alloc_req while empty is ignored.
- Tags pushed in cycle N are poppable from cycle N+1 only; there is no push-to-pop bypass.
- free_count next = free_count + pushes − pop. Simultaneous pop and 2 pushes is legal.
- Overflow: any push that would make free_count exceed NUM_TAGS is dropped and sets fl_overflow, which stays set until rst. Legal operation never overflows.
- ARF read: rs_data[i] is combinational.
  - rs_addr 0 returns 0.
  - Otherwise, if a live committing slot targets rs_addr[i] this cycle, rs_data returns that slot's retire_reg_data (slot 1 over slot 0).
  - Otherwise rs_data returns ARF[rs_addr[i]].

Test Plan:
- Reset, then idle: free_count=32, alloc_tag=32. Pop 3 cycles with alloc_req=1 → alloc_tag goes 32,33,34; free_count=29.
- Retire slot0 reg5/tag40/0xDEAD, same cycle rs_addr0=5 → rs_data0=0xDEAD that cycle (bypass). Next cycle ARF[5]=0xDEAD and tag 5 is pushed; free_count +1.
- Retire both slots to reg7 (tag41 data 0x1, tag42 data 0x2) → ARF[7]=0x2, map[7]=42. Pushes are 7 then 41; after draining the earlier 32..63 entries, pops return 7 then 41.
- retire_valid=2'b10, and separately retire_tag=0 or retire_reg=0 → no ARF change, free_count unchanged.
- Pop to empty (32 pops): alloc_valid=0. Then alloc_req=1 with one retire push → no pop that cycle; next cycle alloc_valid=1 with the freed tag.
- Force an extra push at free_count=64 → push dropped, fl_overflow=1, holds until rst; rst mid-operation restores all reset values.
